// File: rtl/core_pkg.sv
// Shared core definitions for register-file addressing.
//   NREGS      - number of architectural integer registers
//   REG_ADDR_W - width of a register address
//   reg_addr_t - register address type
//   ZERO_REG   - address of x0, which is never tracked
package core_pkg;

  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback handshake between decode, writeback and the register-file scoreboard.
//   master : decode/writeback side, drives issue, writeback and flush requests
//   slave  : scoreboard side, returns stall, fire, per-register busy and sticky error
interface regfile_scoreboard_if #(
  parameter int unsigned NREGS = core_pkg::NREGS
);
  import core_pkg::*;

  logic             issue_valid_i;
  reg_addr_t        rs1_i;
  reg_addr_t        rs2_i;
  reg_addr_t        rd_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic             rd_wr_i;
  logic             wb_valid_i;
  reg_addr_t        wb_rd_i;
  logic             flush_i;
  logic             stall_o;
  logic             issue_fire_o;
  logic [NREGS-1:0] busy_o;
  logic             err_o;

  modport master (
    output issue_valid_i, rs1_i, rs2_i, rd_i, rs1_used_i, rs2_used_i, rd_wr_i,
    output wb_valid_i, wb_rd_i, flush_i,
    input  stall_o, issue_fire_o, busy_o, err_o
  );

  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, rd_i, rs1_used_i, rs2_used_i, rd_wr_i,
    input  wb_valid_i, wb_rd_i, flush_i,
    output stall_o, issue_fire_o, busy_o, err_o
  );

endinterface

// File: rtl/regfile_scoreboard_counter.sv
// sb_counter: saturating up/down pending-write counter for one register.
//   clk, rst  - clock, asynchronous active-high reset
//   inc, dec  - one issued write / one retired write; both together leave the count unchanged
//   clr       - clear to zero, overrides inc/dec
//   cnt       - current count
//   underflow - a lone retire arrived while the count was already zero
module sb_counter #(
  parameter int unsigned CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  input  logic            clr,
  output logic [CNTW-1:0] cnt,
  output logic            underflow
);

  localparam logic [CNTW-1:0] CntMax = '1;

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !dec && cnt_q != CntMax) begin
      cnt_q <= cnt_q + CNTW'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_q <= cnt_q - CNTW'(1);
    end
  end

  assign cnt       = cnt_q;
  assign underflow = dec && !inc && !clr && (cnt_q == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file hazard scoreboard. Counts in-flight writes per architectural register and
// stalls issue on RAW hazards or when a destination's counter is saturated.
//   clk, rst - clock, asynchronous active-high reset
//   sb       - slave side of the issue/writeback interface (stall, fire, busy, sticky error)
module regfile_scoreboard #(
  parameter int unsigned NREGS = core_pkg::NREGS,
  parameter int unsigned CNTW  = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave sb
);
  import core_pkg::*;

  localparam logic [CNTW-1:0] CntMax = '1;

  logic [CNTW-1:0]  cnt [NREGS];
  logic [NREGS-1:0] uf;
  logic             raw1, raw2, waw_sat;
  logic             stall, fire;
  logic [NREGS-1:0] busy;
  logic             err_q;

  // x0 is never tracked.
  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  // Hazards see only registered counters: a writeback clears its hazard one cycle later.
  assign raw1    = sb.rs1_used_i && (sb.rs1_i != ZERO_REG) && (cnt[sb.rs1_i] != '0);
  assign raw2    = sb.rs2_used_i && (sb.rs2_i != ZERO_REG) && (cnt[sb.rs2_i] != '0);
  assign waw_sat = sb.rd_wr_i && (sb.rd_i != ZERO_REG) && (cnt[sb.rd_i] == CntMax);

  assign stall = !rst && sb.issue_valid_i && (raw1 || raw2 || waw_sat);
  assign fire  = !rst && sb.issue_valid_i && !stall;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    logic inc, dec;
    assign inc = fire && sb.rd_wr_i && (sb.rd_i == reg_addr_t'(r));
    assign dec = sb.wb_valid_i && (sb.wb_rd_i == reg_addr_t'(r));

    sb_counter #(
      .CNTW(CNTW)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc),
      .dec       (dec),
      .clr       (sb.flush_i),
      .cnt       (cnt[r]),
      .underflow (uf[r])
    );
  end

  // Sticky: only reset clears it; a flush cycle's writeback is never an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!sb.flush_i && (|uf)) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREGS; r++) begin
      busy[r] = (cnt[r] != '0);
    end
  end

  assign sb.stall_o      = stall;
  assign sb.issue_fire_o = fire;
  assign sb.busy_o       = busy;
  assign sb.err_o        = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a table of one-cycle vectors with expected
// combinational outputs (before the edge) and registered state (after the edge), plus
// hand-written reset sequences.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_scoreboard_if #(.NREGS(32)) sb_if ();

  regfile_scoreboard #(
    .NREGS(32),
    .CNTW (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    int          rs1;
    bit          u1;
    int          rs2;
    bit          u2;
    int          rd;
    bit          wr;
    bit          wv;
    int          wrd;
    bit          fl;
    bit          stall;
    bit          fire;
    logic [31:0] busy;
    bit          err;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input vec_t v);
    sb_if.issue_valid_i = v.iv;
    sb_if.rs1_i         = 5'(v.rs1);
    sb_if.rs1_used_i    = v.u1;
    sb_if.rs2_i         = 5'(v.rs2);
    sb_if.rs2_used_i    = v.u2;
    sb_if.rd_i          = 5'(v.rd);
    sb_if.rd_wr_i       = v.wr;
    sb_if.wb_valid_i    = v.wv;
    sb_if.wb_rd_i       = 5'(v.wrd);
    sb_if.flush_i       = v.fl;
  endtask

  vec_t idle;

  initial begin
    //           iv rs1 u1 rs2 u2 rd wr wv wrd fl  stall fire busy          err
    // RAW on x5
    tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0020, 0};
    tbl[2]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0020, 0};
    tbl[3]  = '{1, 5, 1, 0, 0, 0, 0, 1, 5, 0,  1, 0, 32'h0000_0000, 0};
    tbl[4]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'h0000_0000, 0};
    // WAW saturation on x7
    tbl[5]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 32'h0000_0080, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 7, 1, 1, 7, 0,  1, 0, 32'h0000_0080, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 1, 32'h0000_0080, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0000_0080, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0000_0080, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 32'h0000_0000, 0};
    // Simultaneous issue and writeback on x9
    tbl[14] = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  0, 1, 32'h0000_0200, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 9, 1, 1, 9, 0,  0, 1, 32'h0000_0200, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 32'h0000_0000, 0};
    // x0 and unused sources
    tbl[17] = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 0};
    tbl[18] = '{1, 0, 1, 5, 0, 0, 1, 0, 0, 0,  0, 1, 32'h0000_0020, 0};
    tbl[19] = '{0, 5, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0020, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 32'h0000_0020, 0};
    // Flush and sticky error
    tbl[21] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 1, 32'h0000_0028, 0};
    tbl[22] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 1, 32'h0000_0038, 0};
    tbl[23] = '{1, 3, 1, 0, 0, 0, 0, 1, 3, 1,  1, 0, 32'h0000_0000, 0};
    tbl[24] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 32'h0000_0000, 1};
    tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0000_0000, 1};

    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0, 0};
    drive(idle);

    // Reset state
    #12;
    chk("reset_busy", sb_if.busy_o, 32'h0);
    chk("reset_stall", 32'(sb_if.stall_o), 32'h0);
    chk("reset_fire", 32'(sb_if.issue_fire_o), 32'h0);
    chk("reset_err", 32'(sb_if.err_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(sb_if.stall_o), 32'(tbl[i].stall));
      chk($sformatf("v%0d_fire", i), 32'(sb_if.issue_fire_o), 32'(tbl[i].fire));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), sb_if.busy_o, tbl[i].busy);
      chk($sformatf("v%0d_err", i), 32'(sb_if.err_o), 32'(tbl[i].err));
    end

    // Sticky error survives idle cycles, cleared only by reset
    @(negedge clk);
    drive(idle);
    @(posedge clk);
    #1;
    chk("err_sticky", 32'(sb_if.err_o), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", 32'(sb_if.err_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-operation discards pending state immediately
    @(negedge clk);
    sb_if.issue_valid_i = 1'b1;
    sb_if.rd_i          = 5'd10;
    sb_if.rd_wr_i       = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy_before", sb_if.busy_o, 32'h0000_0400);
    sb_if.rd_wr_i    = 1'b0;
    sb_if.rs1_i      = 5'd10;
    sb_if.rs1_used_i = 1'b1;
    #1;
    chk("midrst_stall_before", 32'(sb_if.stall_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", sb_if.busy_o, 32'h0);
    chk("midrst_stall", 32'(sb_if.stall_o), 32'h0);
    chk("midrst_fire", 32'(sb_if.issue_fire_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_stall", 32'(sb_if.stall_o), 32'h0);
    chk("after_rst_fire", 32'(sb_if.issue_fire_o), 32'h1);
    drive(idle);
    @(posedge clk);
    #1;
    chk("after_rst_busy", sb_if.busy_o, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
